// File: rtl/pw_entry_check.sv
// pw_entry_check
//   Keypad entry and password check for the door-lock datapath. Collects
//   decoded keys into a 4-digit BCD display word, issues STAR/HASH pulses,
//   compares a completed entry against PW / PW_TEMP, counts failures,
//   enforces a lockout and signals consumption of a one-time temp password.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   KEY_VALID, KEY_CODE key strobe and code (0-9 digit, 10 *, 11 #, 12 clear, 13 lock)
//   PW, PW_TEMP         stored master / temporary passwords (4 BCD digits)
//   PW_TEMP_EN          PW_TEMP holds a valid value
//   DISPLAY, DIGIT_CNT  entered digits (newest in [3:0]) and their count
//   STAR, HASH, WRONG   one-cycle pulses
//   CORRECT, LOCKED     levels, high throughout OPEN / LOCKOUT
//   PW_TEMP_RESET       one-cycle pulse when the temp password was used
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing entered yet, waiting for a digit
// ENTRY   | collecting digits, # with 4 digits starts a check
// CHECK   | one cycle: compare DISPLAY with PW / PW_TEMP
// OPEN    | door open, CORRECT high, relocks on timeout or lock key
// LOCKOUT | too many failures, all keys ignored until the timer expires

module pw_entry_check #(
  parameter int OPEN_CYCLES = 1000,
  parameter int LOCK_CYCLES = 3000,
  parameter int MAX_FAIL    = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic [15:0] PW,
  input  logic [15:0] PW_TEMP,
  input  logic        PW_TEMP_EN,
  output logic [15:0] DISPLAY,
  output logic [2:0]  DIGIT_CNT,
  output logic        STAR,
  output logic        HASH,
  output logic        CORRECT,
  output logic        WRONG,
  output logic        LOCKED,
  output logic        PW_TEMP_RESET
);

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES);
  // LOCKOUT is entered with the timer loaded, so LOCK_CYCLES-1 gives
  // exactly LOCK_CYCLES cycles with LOCKED high.
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    MAX_F  = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   display_q, display_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic [2:0]    fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          star_q, star_d;
  logic          hash_q, hash_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;
  logic          locked_q, locked_d;
  logic          temp_rst_q, temp_rst_d;

  logic       key_digit, key_star, key_hash, key_clear, key_lock, key_any;
  logic       has_room;
  logic [2:0] fail_inc;
  logic       match_pw, match_temp;

  always_comb begin
    key_digit  = KEY_VALID && (KEY_CODE <= 4'd9);
    key_star   = KEY_VALID && (KEY_CODE == 4'd10);
    key_hash   = KEY_VALID && (KEY_CODE == 4'd11);
    key_clear  = KEY_VALID && (KEY_CODE == 4'd12);
    key_lock   = KEY_VALID && (KEY_CODE == 4'd13);
    key_any    = KEY_VALID && (KEY_CODE <= 4'd12);
    has_room   = (digit_cnt_q < 3'd4);
    fail_inc   = (fail_cnt_q >= MAX_F) ? MAX_F : fail_cnt_q + 3'd1;
    match_pw   = (display_q == PW);
    match_temp = PW_TEMP_EN && (display_q == PW_TEMP);
  end

  always_comb begin
    state_d     = state_q;
    display_d   = display_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    wrong_d     = 1'b0;
    temp_rst_d  = 1'b0;
    star_d      = key_star && (state_q != LOCKOUT);
    hash_d      = key_hash && (state_q != LOCKOUT);

    case (state_q)
      IDLE: begin
        if (key_digit) begin
          if (has_room) begin
            display_d   = {display_q[11:0], KEY_CODE};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
          state_d = ENTRY;
        end else if (key_clear) begin
          display_d   = 16'h0000;
          digit_cnt_d = 3'd0;
        end
      end

      ENTRY: begin
        if (key_digit) begin
          if (has_room) begin
            display_d   = {display_q[11:0], KEY_CODE};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end else if (key_clear) begin
          display_d   = 16'h0000;
          digit_cnt_d = 3'd0;
          state_d     = IDLE;
        end else if (key_hash) begin
          if (!has_room) begin
            state_d = CHECK;
          end else begin
            // Short entry: counts as a failed attempt but never locks out
            // directly; the next real mismatch will.
            wrong_d     = 1'b1;
            fail_cnt_d  = fail_inc;
            display_d   = 16'h0000;
            digit_cnt_d = 3'd0;
            state_d     = IDLE;
          end
        end
      end

      CHECK: begin
        display_d   = 16'h0000;
        digit_cnt_d = 3'd0;
        if (match_pw || match_temp) begin
          state_d    = OPEN;
          timer_d    = T_OPEN;
          fail_cnt_d = 3'd0;
          temp_rst_d = match_temp && !match_pw;
        end else begin
          wrong_d    = 1'b1;
          fail_cnt_d = fail_inc;
          if (fail_inc >= MAX_F) begin
            state_d = LOCKOUT;
            timer_d = T_LOCK;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OPEN: begin
        if (key_lock) begin
          // Relocking also wipes any half-typed new password.
          state_d     = IDLE;
          display_d   = 16'h0000;
          digit_cnt_d = 3'd0;
        end else if (key_any) begin
          timer_d = T_OPEN;
          if (key_digit) begin
            if (has_room) begin
              display_d   = {display_q[11:0], KEY_CODE};
              digit_cnt_d = digit_cnt_q + 3'd1;
            end
          end else begin
            // clear, star and hash all restart the new-password entry
            display_d   = 16'h0000;
            digit_cnt_d = 3'd0;
          end
        end else if (timer_q == '0) begin
          state_d     = IDLE;
          display_d   = 16'h0000;
          digit_cnt_d = 3'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d    = IDLE;
          fail_cnt_d = 3'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        display_d   = 16'h0000;
        digit_cnt_d = 3'd0;
        fail_cnt_d  = 3'd0;
        timer_d     = '0;
      end
    endcase

    correct_d = (state_d == OPEN);
    locked_d  = (state_d == LOCKOUT);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      display_q   <= 16'h0000;
      digit_cnt_q <= 3'd0;
      fail_cnt_q  <= 3'd0;
      timer_q     <= '0;
      star_q      <= 1'b0;
      hash_q      <= 1'b0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      locked_q    <= 1'b0;
      temp_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      display_q   <= display_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      star_q      <= star_d;
      hash_q      <= hash_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      locked_q    <= locked_d;
      temp_rst_q  <= temp_rst_d;
    end
  end

  assign DISPLAY       = display_q;
  assign DIGIT_CNT     = digit_cnt_q;
  assign STAR          = star_q;
  assign HASH          = hash_q;
  assign CORRECT       = correct_q;
  assign WRONG         = wrong_q;
  assign LOCKED        = locked_q;
  assign PW_TEMP_RESET = temp_rst_q;

endmodule
